// File: rtl/img_pkg.sv
// ---------------------------------------------------------------------------
// img_pkg
// Shared definitions for the camera capture path: default frame size (also
// used by the image source model), capture FSM encoding, bytes per pixel and
// a helper returning a safe counter width for a given element count.
// ---------------------------------------------------------------------------
package img_pkg;

    localparam int N_DEFAULT = 450;
    localparam int M_DEFAULT = 450;
    localparam int BPP       = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_e;

    // Counter width for n distinct values, never narrower than one bit.
    function automatic int widthOf(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/image_capture_if.sv
// ---------------------------------------------------------------------------
// image_capture_if
// Bundles the camera byte stream (camera_en / data_valid / data_in) and the
// frame-buffer write port (pix_we / pix_addr / pix_data / x / y).
//   master : the capture block (drives camera_en and the write port)
//   slave  : source + frame buffer side (drives data_valid / data_in)
// ---------------------------------------------------------------------------
interface image_capture_if #(
    parameter int N = img_pkg::N_DEFAULT,
    parameter int M = img_pkg::M_DEFAULT
);

    localparam int AW = img_pkg::widthOf(N * M);
    localparam int XW = img_pkg::widthOf(N);
    localparam int YW = img_pkg::widthOf(M);

    logic          camera_en;
    logic          data_valid;
    logic [7:0]    data_in;
    logic          pix_we;
    logic [AW-1:0] pix_addr;
    logic [23:0]   pix_data;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    modport master (
        output camera_en, pix_we, pix_addr, pix_data, x, y,
        input  data_valid, data_in
    );

    modport slave (
        input  camera_en, pix_we, pix_addr, pix_data, x, y,
        output data_valid, data_in
    );

endinterface

// File: rtl/image_capture_pixel_packer.sv
// ---------------------------------------------------------------------------
// pixel_packer
// Decides when an accepted byte completes a pixel and presents the packed
// 24-bit value.
//   phase_i      : byte phase of the byte currently on the bus (0..BPP-1)
//   asm_i        : {byte0, byte1, current byte}
//   data_valid_i : byte is being accepted this cycle
//   pix_done_o   : current byte completes a pixel
//   pix_data_o   : packed pixel, first byte in [23:16]
// ---------------------------------------------------------------------------
module pixel_packer
    import img_pkg::*;
(
    input  logic [1:0]  phase_i,
    input  logic [23:0] asm_i,
    input  logic        data_valid_i,
    output logic        pix_done_o,
    output logic [23:0] pix_data_o
);

    assign pix_done_o = data_valid_i && (phase_i == 2'(BPP - 1));
    assign pix_data_o = asm_i;

endmodule

// File: rtl/image_capture.sv
// ---------------------------------------------------------------------------
// image_capture
// Requests one frame from the camera source, packs every three accepted
// bytes into a 24-bit pixel and writes it to the frame buffer at a linear
// address, pulsing frame_done with the last of N*M pixels.
//   clk, rst   : system clock, asynchronous active-high reset
//   start      : one-cycle capture request, honoured only in IDLE
//   busy       : high from the cycle after start until the frame_done cycle
//   frame_done : one-cycle pulse alongside the final pixel write
//   bus        : camera stream in, frame-buffer write port out
// ---------------------------------------------------------------------------
module image_capture
    import img_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int M = M_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic frame_done,
    image_capture_if.master bus
);

    localparam int AW = widthOf(N * M);
    localparam int XW = widthOf(N);
    localparam int YW = widthOf(M);

    state_e        state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [15:0]   shift_q, shift_d;
    logic [AW-1:0] pixCnt_q, pixCnt_d;
    logic [XW-1:0] xCnt_q, xCnt_d;
    logic [YW-1:0] yCnt_q, yCnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [23:0]   data_q, data_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    logic          accept;
    logic          pixDone;
    logic          lastPixel;
    logic [23:0]   packedData;
    logic          cameraEn;

    // Bytes outside CAPTURE (including the source's trailing byte) are dropped.
    assign accept    = (state_q == CAPTURE) && bus.data_valid;
    assign lastPixel = pixDone && (pixCnt_q == AW'(N * M - 1));

    pixel_packer u_packer (
        .phase_i      (phase_q),
        .asm_i        ({shift_q, bus.data_in}),
        .data_valid_i (accept),
        .pix_done_o   (pixDone),
        .pix_data_o   (packedData)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CAPTURE;
            CAPTURE: if (lastPixel) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the registered state
    always_comb begin
        cameraEn   = (state_q == CAPTURE);
        busy       = (state_q != IDLE);
        frame_done = (state_q == DONE);
    end

    // Byte assembly, pixel counters and write-port next values.
    // The linear address is its own counter so no y*N multiply is needed.
    always_comb begin
        phase_d  = phase_q;
        shift_d  = shift_q;
        pixCnt_d = pixCnt_q;
        xCnt_d   = xCnt_q;
        yCnt_d   = yCnt_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        x_d      = x_q;
        y_d      = y_q;
        if (state_q == IDLE && start) begin
            phase_d  = '0;
            pixCnt_d = '0;
            xCnt_d   = '0;
            yCnt_d   = '0;
        end else if (accept) begin
            if (pixDone) begin
                phase_d = '0;
                we_d    = 1'b1;
                data_d  = packedData;
                addr_d  = pixCnt_q;
                x_d     = xCnt_q;
                y_d     = yCnt_q;
                if (!lastPixel) begin
                    pixCnt_d = pixCnt_q + 1'b1;
                    if (xCnt_q == XW'(N - 1)) begin
                        xCnt_d = '0;
                        yCnt_d = yCnt_q + 1'b1;
                    end else begin
                        xCnt_d = xCnt_q + 1'b1;
                    end
                end
            end else begin
                phase_d = phase_q + 1'b1;
                shift_d = {shift_q[7:0], bus.data_in};
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= '0;
            shift_q  <= '0;
            pixCnt_q <= '0;
            xCnt_q   <= '0;
            yCnt_q   <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            phase_q  <= phase_d;
            shift_q  <= shift_d;
            pixCnt_q <= pixCnt_d;
            xCnt_q   <= xCnt_d;
            yCnt_q   <= yCnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    assign bus.camera_en = cameraEn;
    assign bus.pix_we    = we_q;
    assign bus.pix_addr  = addr_q;
    assign bus.pix_data  = data_q;
    assign bus.x         = x_q;
    assign bus.y         = y_q;

endmodule

// File: tb/tb_image_capture.sv
// ---------------------------------------------------------------------------
// tb_image_capture
// Bench for image_capture with a 4x2 frame (24 bytes, 8 pixels). A table of
// frame descriptions drives complete captures; a scoreboard queue holds the
// expected pixel writes and is drained by a monitor on the falling edge.
// ---------------------------------------------------------------------------
module tb_image_capture;

    localparam int N = 4;
    localparam int M = 2;
    localparam int NPIX = N * M;
    localparam int NBYTES = NPIX * 3;

    typedef struct {
        logic [2:0]  addr;
        logic [1:0]  x;
        logic [0:0]  y;
        logic [23:0] data;
        logic        done;
    } pixExp_t;

    typedef struct {
        logic [7:0]  first;
        logic [7:0]  step;
        int          gap;
        bit          extra;
        bit          startMid;
        bit          startDone;
        logic [23:0] expPix0;
        logic [23:0] expPixLast;
    } frameVec_t;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic frameDone;

    int checks = 0;
    int fails = 0;
    int pixWrites = 0;
    int frameDoneCnt = 0;
    logic [23:0] firstPix;
    logic [23:0] lastPix;
    pixExp_t sbQ[$];
    frameVec_t vecs[5];

    image_capture_if #(.N(N), .M(M)) bus ();

    image_capture #(.N(N), .M(M)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .frame_done (frameDone),
        .bus        (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] byteAt(input logic [7:0] first, input logic [7:0] step, input int i);
        return 8'(int'(first) + i * int'(step));
    endfunction

    // Drive count bytes starting at the current falling edge, pushing the
    // expected write for every completed pixel.
    task automatic driveBytes(input logic [7:0] first, input logic [7:0] step,
                              input int gap, input int count, input int startIdx);
        pixExp_t e;
        for (int i = 0; i < count; i++) begin
            bus.data_valid = 1'b1;
            bus.data_in    = byteAt(first, step, i);
            start          = (i == startIdx);
            if (i % 3 == 2) begin
                e.addr = 3'(i / 3);
                e.x    = 2'((i / 3) % N);
                e.y    = 1'((i / 3) / N);
                e.data = {byteAt(first, step, i - 2), byteAt(first, step, i - 1), byteAt(first, step, i)};
                e.done = ((i / 3) == NPIX - 1);
                sbQ.push_back(e);
            end
            @(negedge clk);
            start = 1'b0;
            if (i != count - 1) begin
                for (int g = 0; g < gap; g++) begin
                    bus.data_valid = 1'b0;
                    bus.data_in    = 'z;
                    @(negedge clk);
                end
            end
        end
        bus.data_valid = 1'b0;
        bus.data_in    = 'z;
    endtask

    task automatic startFrame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("cameraEnAfterStart", 32'(bus.camera_en), 32'd1);
        checkOutput("busyAfterStart", 32'(busy), 32'd1);
    endtask

    // One full frame described by a table entry, including the DONE cycle.
    task automatic applyStimulus(input frameVec_t v);
        int writesBefore;
        int donesBefore;
        writesBefore = pixWrites;
        donesBefore  = frameDoneCnt;
        firstPix     = 'x;
        lastPix      = 'x;
        startFrame();
        driveBytes(v.first, v.step, v.gap, NBYTES, v.startMid ? 10 : -1);
        checkOutput("cameraEnLowInDone", 32'(bus.camera_en), 32'd0);
        checkOutput("frameDoneHigh", 32'(frameDone), 32'd1);
        checkOutput("busyInDone", 32'(busy), 32'd1);
        bus.data_valid = v.extra;
        bus.data_in    = v.extra ? 8'hAA : 8'hzz;
        start          = v.startDone;
        @(negedge clk);
        bus.data_valid = 1'b0;
        bus.data_in    = 'z;
        start          = 1'b0;
        checkOutput("busyAfterDone", 32'(busy), 32'd0);
        checkOutput("frameDoneAfter", 32'(frameDone), 32'd0);
        checkOutput("weAfterDone", 32'(bus.pix_we), 32'd0);
        @(negedge clk);
        checkOutput("noSecondCapture", 32'(busy), 32'd0);
        checkOutput("cameraEnIdle", 32'(bus.camera_en), 32'd0);
        checkOutput("sbDrained", 32'(sbQ.size()), 32'd0);
        checkOutput("pixWritesPerFrame", 32'(pixWrites - writesBefore), 32'(NPIX));
        checkOutput("frameDonePerFrame", 32'(frameDoneCnt - donesBefore), 32'd1);
        checkOutput("firstPixel", 32'(firstPix), 32'(v.expPix0));
        checkOutput("lastPixel", 32'(lastPix), 32'(v.expPixLast));
    endtask

    // Monitor: compares every write against the scoreboard
    initial begin : monitor
        pixExp_t e;
        logic prevWe;
        prevWe = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevWe = 1'b0;
            end else begin
                if (prevWe) checkOutput("weOnePulse", 32'(bus.pix_we), 32'd0);
                if (frameDone === 1'b1) begin
                    frameDoneCnt++;
                    checkOutput("doneWithWe", 32'(bus.pix_we), 32'd1);
                end
                if (bus.pix_we !== 1'b0) begin
                    if (sbQ.size() == 0) begin
                        checks++;
                        fails++;
                        $display("[TB] FAIL unexpectedWrite: pix_we=%b addr=%0d data=%0h, expected no write", bus.pix_we, bus.pix_addr, bus.pix_data);
                    end else begin
                        e = sbQ.pop_front();
                        checkOutput("pixAddr", 32'(bus.pix_addr), 32'(e.addr));
                        checkOutput("pixX", 32'(bus.x), 32'(e.x));
                        checkOutput("pixY", 32'(bus.y), 32'(e.y));
                        checkOutput("pixData", 32'(bus.pix_data), 32'(e.data));
                        checkOutput("pixDone", 32'(frameDone), 32'(e.done));
                        pixWrites++;
                        if (bus.pix_addr == 3'd0) firstPix = bus.pix_data;
                        if (bus.pix_addr == 3'(NPIX - 1)) lastPix = bus.pix_data;
                    end
                end
                prevWe = (bus.pix_we === 1'b1);
            end
        end
    end

    initial begin
        vecs[0] = '{first: 8'h00, step: 8'h01, gap: 0, extra: 1'b0, startMid: 1'b0, startDone: 1'b0,
                    expPix0: 24'h000102, expPixLast: 24'h151617};
        vecs[1] = '{first: 8'h00, step: 8'h01, gap: 2, extra: 1'b0, startMid: 1'b0, startDone: 1'b0,
                    expPix0: 24'h000102, expPixLast: 24'h151617};
        vecs[2] = '{first: 8'h00, step: 8'h01, gap: 0, extra: 1'b1, startMid: 1'b0, startDone: 1'b0,
                    expPix0: 24'h000102, expPixLast: 24'h151617};
        vecs[3] = '{first: 8'h10, step: 8'h10, gap: 0, extra: 1'b0, startMid: 1'b0, startDone: 1'b0,
                    expPix0: 24'h102030, expPixLast: 24'h607080};
        vecs[4] = '{first: 8'hA0, step: 8'h03, gap: 1, extra: 1'b0, startMid: 1'b1, startDone: 1'b1,
                    expPix0: 24'hA0A3A6, expPixLast: 24'hDFE2E5};

        rst = 1'b1;
        start = 1'b0;
        bus.data_valid = 1'b0;
        bus.data_in = 'z;
        repeat (2) @(negedge clk);
        checkOutput("rstCameraEn", 32'(bus.camera_en), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstPixWe", 32'(bus.pix_we), 32'd0);
        checkOutput("rstFrameDone", 32'(frameDone), 32'd0);
        checkOutput("rstPixAddr", 32'(bus.pix_addr), 32'd0);
        checkOutput("rstPixData", 32'(bus.pix_data), 32'd0);
        rst = 1'b0;

        $display("[TB] idle bytes with floating data");
        @(negedge clk);
        bus.data_valid = 1'b1;
        bus.data_in = 'z;
        repeat (3) @(negedge clk);
        bus.data_valid = 1'b0;
        checkOutput("idleNoWe", 32'(bus.pix_we), 32'd0);
        checkOutput("idleDataKnown", 32'($isunknown(bus.pix_data)), 32'd0);
        checkOutput("idleAddrKnown", 32'($isunknown(bus.pix_addr)), 32'd0);
        checkOutput("idleDataZero", 32'(bus.pix_data), 32'd0);
        checkOutput("idleBusy", 32'(busy), 32'd0);

        $display("[TB] reset in the middle of a capture");
        startFrame();
        driveBytes(8'h55, 8'h01, 0, 5, -1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midRstCameraEn", 32'(bus.camera_en), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstPixData", 32'(bus.pix_data), 32'd0);
        checkOutput("midRstPixAddr", 32'(bus.pix_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midRstNoFrameDone", 32'(frameDoneCnt), 32'd0);
        checkOutput("midRstSbEmpty", 32'(sbQ.size()), 32'd0);

        for (int k = 0; k < 5; k++) begin
            $display("[TB] frame vector %0d", k);
            applyStimulus(vecs[k]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
